// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types used by the L1/L2 arbiter.
// L2_ARBITER_RR_EN selects the round-robin picker, not anything in this package.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection for l2_arbiter_rr.
// L2_ARBITER_RR_EN defined: round-robin from i_rr_ptr; undefined: lowest index wins.
module arb_rr_picker #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned IDX_W       = 1
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
`ifdef L2_ARBITER_RR_EN
    input  logic [IDX_W-1:0]       i_rr_ptr,
`endif
    output logic [IDX_W-1:0]       o_win_idx,
    output logic                   o_any_req
);

    assign o_any_req = |i_req;

`ifdef L2_ARBITER_RR_EN
    // One spare bit so ptr+offset never overflows before the wrap subtraction.
    logic [IDX_W:0] w_cand;
    logic           w_found;

    always_comb begin
        o_win_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_cand = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_CLIENTS)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_CLIENTS);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                o_win_idx = w_cand[IDX_W-1:0];
            end
        end
    end
`else
    always_comb begin
        o_win_idx = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_win_idx = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/l2_arbiter_rr.sv
// N-client L1-to-L2 port arbiter; grant held from IDLE pick until l2_mem_resp.
// L2_ARBITER_RR_EN defined: round-robin fairness; undefined: fixed priority (client 0 first).
module l2_arbiter_rr #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_address,
    input  logic [NUM_CLIENTS-1:0]                 cl_read,
    input  logic [NUM_CLIENTS-1:0]                 cl_write,
    input  logic [NUM_CLIENTS-1:0][LINE_WIDTH-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0][LINE_WIDTH-1:0] cl_rdata,
    output logic [NUM_CLIENTS-1:0]                 cl_mem_resp,
    input  logic [LINE_WIDTH-1:0]                  l2_rdata,
    input  logic                                   l2_mem_resp,
    output logic [ADDR_WIDTH-1:0]                  l2_address,
    output logic [LINE_WIDTH-1:0]                  l2_wdata,
    output logic                                   l2_read,
    output logic                                   l2_write,
    output logic [NUM_CLIENTS-1:0]                 grant_vec,
    output logic                                   busy
);

    import lc3b_types::*;

    localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

    arb_state_t               r_state;
    logic [IDX_W-1:0]         r_grant_idx;
    logic [NUM_CLIENTS-1:0]   r_grant_vec;
    logic                     r_busy;

    logic [NUM_CLIENTS-1:0]   w_req;
    logic [IDX_W-1:0]         w_win;
    logic                     w_any_req;

    assign w_req = cl_read | cl_write;

`ifdef L2_ARBITER_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_next;

    assign w_rr_next = (r_grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0
                                                                 : r_grant_idx + IDX_W'(1);
`endif

    arb_rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req     (w_req),
`ifdef L2_ARBITER_RR_EN
        .i_rr_ptr  (r_rr_ptr),
`endif
        .o_win_idx (w_win),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_grant_vec <= '0;
            r_busy      <= 1'b0;
`ifdef L2_ARBITER_RR_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state     <= BUSY;
                        r_grant_idx <= w_win;
                        r_grant_vec <= NUM_CLIENTS'(1) << w_win;
                        r_busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    // Grant is held regardless of request lines until L2 completes.
                    if (l2_mem_resp) begin
                        r_state     <= IDLE;
                        r_grant_vec <= '0;
                        r_busy      <= 1'b0;
`ifdef L2_ARBITER_RR_EN
                        r_rr_ptr    <= w_rr_next;
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_grant_vec <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        l2_address  = '0;
        l2_wdata    = '0;
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        cl_rdata    = '0;
        cl_mem_resp = '0;
        if (r_state == BUSY) begin
            l2_address                = cl_address[r_grant_idx];
            l2_wdata                  = cl_wdata[r_grant_idx];
            l2_read                   = cl_read[r_grant_idx];
            l2_write                  = cl_write[r_grant_idx];
            cl_rdata[r_grant_idx]     = l2_rdata;
            cl_mem_resp[r_grant_idx]  = l2_mem_resp;
        end
    end

    assign grant_vec = r_grant_vec;
    assign busy      = r_busy;

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Directed bench for l2_arbiter_rr: a 2-client instance driven from a vector table,
// plus hand sequences for contention, reset mid-BUSY and 3-client pointer wrap.
module tb_l2_arbiter_rr;

    localparam logic [15:0]  A0 = 16'h0040;
    localparam logic [15:0]  A1 = 16'h1230;
    localparam logic [127:0] W0 = {16{8'h5A}};
    localparam logic [127:0] W1 = {16{8'hC3}};
    localparam logic [127:0] RD = 128'hDEAD_0123_4567_89AB_CDEF_0123_4567_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2-client instance
    logic [1:0][15:0]  addr2;
    logic [1:0]        rd2, wr2, clresp2, gv2;
    logic [1:0][127:0] wdata2, rdata2;
    logic              resp2, l2rd2, l2wr2, busy2;
    logic [15:0]       l2addr2;
    logic [127:0]      l2wdata2;

    // 3-client instance
    logic [2:0][15:0]  addr3;
    logic [2:0]        rd3, wr3, clresp3, gv3;
    logic [2:0][127:0] wdata3, rdata3;
    logic              resp3, l2rd3, l2wr3, busy3;
    logic [15:0]       l2addr3;
    logic [127:0]      l2wdata3;

    l2_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut2 (
        .clk(clk), .rst(rst), .cl_address(addr2), .cl_read(rd2), .cl_write(wr2),
        .cl_wdata(wdata2), .cl_rdata(rdata2), .cl_mem_resp(clresp2), .l2_rdata(RD),
        .l2_mem_resp(resp2), .l2_address(l2addr2), .l2_wdata(l2wdata2), .l2_read(l2rd2),
        .l2_write(l2wr2), .grant_vec(gv2), .busy(busy2)
    );

    l2_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut3 (
        .clk(clk), .rst(rst), .cl_address(addr3), .cl_read(rd3), .cl_write(wr3),
        .cl_wdata(wdata3), .cl_rdata(rdata3), .cl_mem_resp(clresp3), .l2_rdata(RD),
        .l2_mem_resp(resp3), .l2_address(l2addr3), .l2_wdata(l2wdata3), .l2_read(l2rd3),
        .l2_write(l2wr3), .grant_vec(gv3), .busy(busy3)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        resp;
        logic [1:0]  gnt;
        logic        bsy;
        logic        l2rd;
        logic        l2wr;
        logic [15:0] addr;
        logic [1:0]  clr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] rd, logic [1:0] wr, logic resp, logic [1:0] gnt,
                                logic bsy, logic l2rd, logic l2wr, logic [15:0] addr,
                                logic [1:0] clr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.resp = resp; v.gnt = gnt; v.bsy = bsy;
        v.l2rd = l2rd; v.l2wr = l2wr; v.addr = addr; v.clr = clr;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t              vecs[18];
    logic [1:0]        exp2[4];
    logic [2:0]        exp3[4];
    logic [127:0]      exp_wd;
    logic [1:0][127:0] exp_rd;
    int                gap;

    initial begin
        rd2 = '0; wr2 = '0; resp2 = 1'b0;
        addr2[0] = A0; addr2[1] = A1; wdata2[0] = W0; wdata2[1] = W1;
        rd3 = '0; wr3 = '0; resp3 = 1'b0; addr3 = '0; wdata3 = '0;

`ifdef L2_ARBITER_RR_EN
        exp2[0] = 2'b01; exp2[1] = 2'b10; exp2[2] = 2'b01; exp2[3] = 2'b10;
        exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;
`else
        for (int i = 0; i < 4; i++) begin
            exp2[i] = 2'b01;
            exp3[i] = 3'b001;
        end
`endif

        //              rd     wr     rsp  gnt    bsy  l2rd l2wr addr   clresp
        vecs[0]  = mk(2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00); // idle after reset
        vecs[1]  = mk(2'b00, 2'b00, 1'b1, 2'b00, 0, 0, 0, 16'h0, 2'b00); // stray response
        vecs[2]  = mk(2'b10, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00); // client 1 read seen
        vecs[3]  = mk(2'b10, 2'b00, 1'b0, 2'b10, 1, 1, 0, A1,    2'b00);
        vecs[4]  = mk(2'b10, 2'b00, 1'b0, 2'b10, 1, 1, 0, A1,    2'b00);
        vecs[5]  = mk(2'b10, 2'b00, 1'b1, 2'b10, 1, 1, 0, A1,    2'b10);
        vecs[6]  = mk(2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00);
        vecs[7]  = mk(2'b00, 2'b01, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00); // client 0 write
        vecs[8]  = mk(2'b00, 2'b01, 1'b0, 2'b01, 1, 0, 1, A0,    2'b00);
        vecs[9]  = mk(2'b00, 2'b01, 1'b1, 2'b01, 1, 0, 1, A0,    2'b01);
        vecs[10] = mk(2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00);
        vecs[11] = mk(2'b01, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00); // dropped request
        vecs[12] = mk(2'b00, 2'b00, 1'b0, 2'b01, 1, 0, 0, A0,    2'b00);
        vecs[13] = mk(2'b00, 2'b00, 1'b1, 2'b01, 1, 0, 0, A0,    2'b01);
        vecs[14] = mk(2'b01, 2'b01, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00); // read+write
        vecs[15] = mk(2'b01, 2'b01, 1'b0, 2'b01, 1, 1, 1, A0,    2'b00);
        vecs[16] = mk(2'b01, 2'b01, 1'b1, 2'b01, 1, 1, 1, A0,    2'b01);
        vecs[17] = mk(2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 16'h0, 2'b00);

        // Outputs must be zero while reset is asserted.
        #2;
        chk("reset_hold", {gv2, busy2, l2rd2, l2wr2, l2addr2, l2wdata2, clresp2, rdata2}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rd2 = vecs[i].rd; wr2 = vecs[i].wr; resp2 = vecs[i].resp;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                {gv2, busy2, l2rd2, l2wr2, l2addr2, clresp2},
                {vecs[i].gnt, vecs[i].bsy, vecs[i].l2rd, vecs[i].l2wr, vecs[i].addr,
                 vecs[i].clr});
            exp_wd    = vecs[i].gnt[1] ? W1 : (vecs[i].gnt[0] ? W0 : '0);
            exp_rd[0] = vecs[i].gnt[0] ? RD : '0;
            exp_rd[1] = vecs[i].gnt[1] ? RD : '0;
            chk($sformatf("vec%0d_data", i), {l2wdata2, rdata2}, {exp_wd, exp_rd});
        end

        // Contention on the 2-client instance, both clients reading continuously.
        do_reset();
        rd2 = 2'b11; wr2 = 2'b00; resp2 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            gap = 0;
            while (!busy2 && gap < 10) begin
                gap++;
                @(negedge clk);
            end
            chk($sformatf("contend%0d_gap", t), gap, 1);
            chk($sformatf("contend%0d_grant", t), gv2, exp2[t]);
            resp2 = 1'b1;
            #1;
            chk($sformatf("contend%0d_resp", t), clresp2, exp2[t]);
            @(negedge clk);
            resp2 = 1'b0;
        end
        rd2 = 2'b00;

        // Reset asserted mid-transaction.
        do_reset();
        rd2 = 2'b01;
        @(negedge clk);
        chk("rst_pre_busy", {gv2, busy2, l2rd2}, {2'b01, 1'b1, 1'b1});
        #2;
        rst   = 1'b1;
        resp2 = 1'b1;
        #1;
        chk("rst_async", {gv2, busy2, l2rd2, l2wr2, l2addr2, l2wdata2, clresp2, rdata2}, '0);
        @(negedge clk);
        rst = 1'b0;
        rd2 = 2'b00;
        for (int t = 0; t < 3; t++) begin
            resp2 = (t == 1);
            #1;
            chk($sformatf("rst_after%0d", t), {gv2, busy2, l2rd2, clresp2}, '0);
            @(negedge clk);
        end
        resp2 = 1'b0;

        // 3-client pointer wrap, all clients reading.
        do_reset();
        rd3 = 3'b111;
        for (int t = 0; t < 4; t++) begin
            gap = 0;
            while (!busy3 && gap < 10) begin
                gap++;
                @(negedge clk);
            end
            chk($sformatf("wrap%0d_gap", t), gap, 1);
            chk($sformatf("wrap%0d_grant", t), gv3, exp3[t]);
            resp3 = 1'b1;
            #1;
            chk($sformatf("wrap%0d_resp", t), clresp3, exp3[t]);
            @(negedge clk);
            resp3 = 1'b0;
        end
        rd3 = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
